// File: rtl/decode.sv
// Decode stage of the 16-bit five-stage pipeline.
// Splits the fetched instruction into fields, reads the 8x16 register file,
// builds execute-stage control and the extended immediate, detects load-use
// hazards and registers everything into the D/E pipeline register.
// Optional build macro: DECODE_WB_BYPASS_EN (writeback-to-read write-through).
module decode #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREG   = 8,
    parameter int unsigned RA_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       instr_d,
    input  logic [DATA_W-1:0] pc_d,
    input  logic [DATA_W-1:0] pc_next_d,
    input  logic              flush_d,
    input  logic              reg_write_w,
    input  logic [RA_W-1:0]   rd_w,
    input  logic [DATA_W-1:0] result_w,
    output logic              stall_f,
    output logic [DATA_W-1:0] rd1_e,
    output logic [DATA_W-1:0] rd2_e,
    output logic [DATA_W-1:0] imm_e,
    output logic [RA_W-1:0]   rs1_e,
    output logic [RA_W-1:0]   rs2_e,
    output logic [RA_W-1:0]   rd_e,
    output logic [2:0]        alu_ctrl_e,
    output logic              alu_src_e,
    output logic              reg_write_e,
    output logic              mem_read_e,
    output logic              mem_write_e,
    output logic              branch_e,
    output logic              jump_e,
    output logic [1:0]        result_src_e,
    output logic [DATA_W-1:0] pc_e,
    output logic [DATA_W-1:0] pc_next_e,
    output logic              illegal_e
);

    localparam logic [3:0] OpRtype = 4'd0;
    localparam logic [3:0] OpAddi  = 4'd1;
    localparam logic [3:0] OpLw    = 4'd2;
    localparam logic [3:0] OpSw    = 4'd3;
    localparam logic [3:0] OpBeq   = 4'd4;
    localparam logic [3:0] OpJal   = 4'd5;
    localparam logic [3:0] OpLui   = 4'd6;

    localparam logic [2:0] AluAdd = 3'd0;
    localparam logic [2:0] AluSub = 3'd1;

    localparam logic [1:0] ResAlu  = 2'd0;
    localparam logic [1:0] ResMem  = 2'd1;
    localparam logic [1:0] ResPc   = 2'd2;
    localparam logic [1:0] ResImm  = 2'd3;

    // Everything the D/E register carries, bundled so bubbles are a single '0.
    typedef struct packed {
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [RA_W-1:0]   rs1;
        logic [RA_W-1:0]   rs2;
        logic [RA_W-1:0]   rd;
        logic [2:0]        alu_ctrl;
        logic              alu_src;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              branch;
        logic              jump;
        logic [1:0]        result_src;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] pc_next;
        logic              illegal;
    } de_t;

    // Instruction fields
    logic [3:0]      op;
    logic [RA_W-1:0] fld_a;
    logic [RA_W-1:0] fld_b;
    logic [RA_W-1:0] fld_c;
    logic [2:0]      fld_f;

    assign op    = instr_d[15:12];
    assign fld_a = instr_d[11:9];
    assign fld_b = instr_d[8:6];
    assign fld_c = instr_d[5:3];
    assign fld_f = instr_d[2:0];

    // Immediate variants
    logic [DATA_W-1:0] imm6_sext;
    logic [DATA_W-1:0] imm6_x2;
    logic [DATA_W-1:0] imm9_x2;
    logic [DATA_W-1:0] imm9_upper;

    // Build every immediate form; the control decoder picks one
    always_comb begin
        imm6_sext  = {{(DATA_W-6){instr_d[5]}}, instr_d[5:0]};
        imm6_x2    = {imm6_sext[DATA_W-2:0], 1'b0};
        imm9_x2    = {{(DATA_W-10){instr_d[8]}}, instr_d[8:0], 1'b0};
        imm9_upper = {instr_d[8:0], {(DATA_W-9){1'b0}}};
    end

    // Decoded (pre-register) values
    logic [RA_W-1:0]   rs1_dec;
    logic [RA_W-1:0]   rs2_dec;
    logic [RA_W-1:0]   rd_dec;
    logic              use_rs1;
    logic              use_rs2;
    logic              writes_rd;
    logic [DATA_W-1:0] imm_dec;
    logic [2:0]        alu_dec;
    logic              alu_src_dec;
    logic              mem_read_dec;
    logic              mem_write_dec;
    logic              branch_dec;
    logic              jump_dec;
    logic [1:0]        res_src_dec;
    logic              illegal_dec;

    // Opcode decoder: register indices, immediate and control per instruction class
    always_comb begin
        rs1_dec       = '0;
        rs2_dec       = '0;
        rd_dec        = '0;
        use_rs1       = 1'b0;
        use_rs2       = 1'b0;
        writes_rd     = 1'b0;
        imm_dec       = '0;
        alu_dec       = AluAdd;
        alu_src_dec   = 1'b0;
        mem_read_dec  = 1'b0;
        mem_write_dec = 1'b0;
        branch_dec    = 1'b0;
        jump_dec      = 1'b0;
        res_src_dec   = ResAlu;
        illegal_dec   = 1'b0;
        case (op)
            OpRtype: begin
                rd_dec    = fld_a;
                rs1_dec   = fld_b;
                rs2_dec   = fld_c;
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                writes_rd = 1'b1;
                alu_dec   = fld_f;
            end
            OpAddi: begin
                rd_dec      = fld_a;
                rs1_dec     = fld_b;
                use_rs1     = 1'b1;
                writes_rd   = 1'b1;
                imm_dec     = imm6_sext;
                alu_src_dec = 1'b1;
            end
            OpLw: begin
                rd_dec       = fld_a;
                rs1_dec      = fld_b;
                use_rs1      = 1'b1;
                writes_rd    = 1'b1;
                imm_dec      = imm6_sext;
                alu_src_dec  = 1'b1;
                mem_read_dec = 1'b1;
                res_src_dec  = ResMem;
            end
            OpSw: begin
                rs1_dec       = fld_b;
                rs2_dec       = fld_a;
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                imm_dec       = imm6_sext;
                alu_src_dec   = 1'b1;
                mem_write_dec = 1'b1;
            end
            OpBeq: begin
                rs1_dec    = fld_a;
                rs2_dec    = fld_b;
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
                imm_dec    = imm6_x2;
                alu_dec    = AluSub;
                branch_dec = 1'b1;
            end
            OpJal: begin
                rd_dec      = fld_a;
                writes_rd   = 1'b1;
                imm_dec     = imm9_x2;
                jump_dec    = 1'b1;
                res_src_dec = ResPc;
            end
            OpLui: begin
                rd_dec      = fld_a;
                writes_rd   = 1'b1;
                imm_dec     = imm9_upper;
                res_src_dec = ResImm;
            end
            default: begin
                illegal_dec = 1'b1;
            end
        endcase
    end

    // Register file (r0 is never written, so it stays 0)
    logic [DATA_W-1:0] rf_q [NREG];
    logic              wb_en;

    assign wb_en = reg_write_w && (rd_w != '0);

    // Writeback port; everything clears on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_en) begin
            rf_q[rd_w] <= result_w;
        end
    end

    logic [DATA_W-1:0] rd1_dec;
    logic [DATA_W-1:0] rd2_dec;

    // Combinational read ports, r0 reads as 0
    always_comb begin
        rd1_dec = (rs1_dec == '0) ? '0 : rf_q[rs1_dec];
        rd2_dec = (rs2_dec == '0) ? '0 : rf_q[rs2_dec];
`ifdef DECODE_WB_BYPASS_EN
        if (wb_en && (rd_w == rs1_dec)) rd1_dec = result_w;
        if (wb_en && (rd_w == rs2_dec)) rd2_dec = result_w;
`endif
    end

    // Pipeline register state
    de_t de_q;
    de_t de_d;
    de_t dec;

    logic load_use;
    logic wb_hazard;

    // Hazard detection: load-use against E, plus same-cycle writeback without bypass
    always_comb begin
        load_use = de_q.mem_read && (de_q.rd != '0) &&
                   ((use_rs1 && (rs1_dec == de_q.rd)) ||
                    (use_rs2 && (rs2_dec == de_q.rd)));
`ifdef DECODE_WB_BYPASS_EN
        wb_hazard = 1'b0;
`else
        wb_hazard = wb_en &&
                    ((use_rs1 && (rs1_dec == rd_w)) ||
                     (use_rs2 && (rs2_dec == rd_w)));
`endif
        stall_f = !flush_d && (load_use || wb_hazard);
    end

    // Assemble the decoded bundle; writes to r0 never raise reg_write
    always_comb begin
        dec            = '0;
        dec.rd1        = rd1_dec;
        dec.rd2        = rd2_dec;
        dec.imm        = imm_dec;
        dec.rs1        = rs1_dec;
        dec.rs2        = rs2_dec;
        dec.rd         = rd_dec;
        dec.alu_ctrl   = alu_dec;
        dec.alu_src    = alu_src_dec;
        dec.reg_write  = writes_rd && (rd_dec != '0);
        dec.mem_read   = mem_read_dec;
        dec.mem_write  = mem_write_dec;
        dec.branch     = branch_dec;
        dec.jump       = jump_dec;
        dec.result_src = res_src_dec;
        dec.pc         = pc_d;
        dec.pc_next    = pc_next_d;
        dec.illegal    = illegal_dec;
    end

    // Next D/E contents: flush and stall both inject an all-zero bubble
    always_comb begin
        de_d = dec;
        if (flush_d || stall_f) begin
            de_d = '0;
        end
    end

    // D/E pipeline register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            de_q <= '0;
        end else begin
            de_q <= de_d;
        end
    end

    assign rd1_e        = de_q.rd1;
    assign rd2_e        = de_q.rd2;
    assign imm_e        = de_q.imm;
    assign rs1_e        = de_q.rs1;
    assign rs2_e        = de_q.rs2;
    assign rd_e         = de_q.rd;
    assign alu_ctrl_e   = de_q.alu_ctrl;
    assign alu_src_e    = de_q.alu_src;
    assign reg_write_e  = de_q.reg_write;
    assign mem_read_e   = de_q.mem_read;
    assign mem_write_e  = de_q.mem_write;
    assign branch_e     = de_q.branch;
    assign jump_e       = de_q.jump;
    assign result_src_e = de_q.result_src;
    assign pc_e         = de_q.pc;
    assign pc_next_e    = de_q.pc_next;
    assign illegal_e    = de_q.illegal;

endmodule

// File: tb/tb_decode.sv
// Self-checking bench for decode: directed scenarios followed by random
// instruction streams, all compared against an instruction-level model.
module tb_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr_d, pc_d, pc_next_d;
    logic        flush_d, reg_write_w;
    logic [2:0]  rd_w;
    logic [15:0] result_w;
    logic        stall_f;
    logic [15:0] rd1_e, rd2_e, imm_e, pc_e, pc_next_e;
    logic [2:0]  rs1_e, rs2_e, rd_e, alu_ctrl_e;
    logic        alu_src_e, reg_write_e, mem_read_e, mem_write_e, branch_e, jump_e;
    logic [1:0]  result_src_e;
    logic        illegal_e;

    decode dut (
        .clk(clk), .rst(rst), .instr_d(instr_d), .pc_d(pc_d), .pc_next_d(pc_next_d),
        .flush_d(flush_d), .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w),
        .stall_f(stall_f), .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .alu_ctrl_e(alu_ctrl_e),
        .alu_src_e(alu_src_e), .reg_write_e(reg_write_e), .mem_read_e(mem_read_e),
        .mem_write_e(mem_write_e), .branch_e(branch_e), .jump_e(jump_e),
        .result_src_e(result_src_e), .pc_e(pc_e), .pc_next_e(pc_next_e),
        .illegal_e(illegal_e)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rd1, rd2, imm, pc, pcn;
        logic [2:0]  rs1, rs2, rd, alu;
        bit          asrc, rw, mr, mw, br, jp, ill;
        logic [1:0]  rsrc;
        bit          u1, u2;
    } exp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] m_rf [8];
    exp_t        exp_e;
    bit          obs_stall;
    logic [15:0] pc = 16'h0100;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sext(input int v, input int bits);
        return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
    endfunction

    function automatic logic [15:0] rf_read(input logic [2:0] r);
        if (r == 0) return 16'h0;
`ifdef DECODE_WB_BYPASS_EN
        if (reg_write_w && rd_w == r) return result_w;
`endif
        return m_rf[r];
    endfunction

    function automatic exp_t zero_e();
        exp_t e;
        e = '{default: 0};
        return e;
    endfunction

    // Instruction-level meaning of each opcode
    function automatic exp_t model_decode(input logic [15:0] ins);
        exp_t e;
        int op, a, b, c, f, i6, i9;
        e = zero_e();
        op = int'(ins[15:12]); a = int'(ins[11:9]); b = int'(ins[8:6]);
        c = int'(ins[5:3]); f = int'(ins[2:0]);
        i6 = sext(int'(ins[5:0]), 6); i9 = sext(int'(ins[8:0]), 9);
        case (op)
            0: begin e.rd = 3'(a); e.rs1 = 3'(b); e.rs2 = 3'(c); e.alu = 3'(f);
                     e.u1 = 1; e.u2 = 1; e.rw = 1; end
            1: begin e.rd = 3'(a); e.rs1 = 3'(b); e.u1 = 1; e.imm = 16'(i6);
                     e.asrc = 1; e.rw = 1; end
            2: begin e.rd = 3'(a); e.rs1 = 3'(b); e.u1 = 1; e.imm = 16'(i6);
                     e.asrc = 1; e.rw = 1; e.mr = 1; e.rsrc = 2'd1; end
            3: begin e.rs2 = 3'(a); e.rs1 = 3'(b); e.u1 = 1; e.u2 = 1; e.imm = 16'(i6);
                     e.asrc = 1; e.mw = 1; end
            4: begin e.rs1 = 3'(a); e.rs2 = 3'(b); e.u1 = 1; e.u2 = 1; e.imm = 16'(i6 * 2);
                     e.alu = 3'd1; e.br = 1; end
            5: begin e.rd = 3'(a); e.imm = 16'(i9 * 2); e.jp = 1; e.rsrc = 2'd2; e.rw = 1; end
            6: begin e.rd = 3'(a); e.imm = 16'(int'(ins[8:0]) * 128); e.rsrc = 2'd3; e.rw = 1; end
            default: e.ill = 1;
        endcase
        if (e.rd == 0) e.rw = 0;
        e.rd1 = rf_read(e.rs1);
        e.rd2 = rf_read(e.rs2);
        e.pc = pc_d; e.pcn = pc_next_d;
        return e;
    endfunction

    function automatic bit model_stall(input exp_t d);
        bit hz;
        hz = exp_e.mr && exp_e.rd != 0 &&
             ((d.u1 && d.rs1 == exp_e.rd) || (d.u2 && d.rs2 == exp_e.rd));
`ifndef DECODE_WB_BYPASS_EN
        if (reg_write_w && rd_w != 0 &&
            ((d.u1 && d.rs1 == rd_w) || (d.u2 && d.rs2 == rd_w))) hz = 1;
`endif
        return hz && !flush_d;
    endfunction

    task automatic compare_outputs(input string ph);
        check_eq({ph, " rd1_e"}, 32'(rd1_e), 32'(exp_e.rd1));
        check_eq({ph, " rd2_e"}, 32'(rd2_e), 32'(exp_e.rd2));
        check_eq({ph, " imm_e"}, 32'(imm_e), 32'(exp_e.imm));
        check_eq({ph, " rs1_e"}, 32'(rs1_e), 32'(exp_e.rs1));
        check_eq({ph, " rs2_e"}, 32'(rs2_e), 32'(exp_e.rs2));
        check_eq({ph, " rd_e"}, 32'(rd_e), 32'(exp_e.rd));
        check_eq({ph, " alu_ctrl_e"}, 32'(alu_ctrl_e), 32'(exp_e.alu));
        check_eq({ph, " alu_src_e"}, 32'(alu_src_e), 32'(exp_e.asrc));
        check_eq({ph, " reg_write_e"}, 32'(reg_write_e), 32'(exp_e.rw));
        check_eq({ph, " mem_read_e"}, 32'(mem_read_e), 32'(exp_e.mr));
        check_eq({ph, " mem_write_e"}, 32'(mem_write_e), 32'(exp_e.mw));
        check_eq({ph, " branch_e"}, 32'(branch_e), 32'(exp_e.br));
        check_eq({ph, " jump_e"}, 32'(jump_e), 32'(exp_e.jp));
        check_eq({ph, " result_src_e"}, 32'(result_src_e), 32'(exp_e.rsrc));
        check_eq({ph, " pc_e"}, 32'(pc_e), 32'(exp_e.pc));
        check_eq({ph, " pc_next_e"}, 32'(pc_next_e), 32'(exp_e.pcn));
        check_eq({ph, " illegal_e"}, 32'(illegal_e), 32'(exp_e.ill));
    endtask

    // One pipeline cycle: drive, check stall, clock, check D/E contents
    task automatic step(input logic [15:0] ins, input bit fl, input bit we,
                        input logic [2:0] wr, input logic [15:0] wd);
        exp_t d;
        bit   st;
        instr_d = ins; pc_d = pc; pc_next_d = pc + 16'd2;
        flush_d = fl; reg_write_w = we; rd_w = wr; result_w = wd;
        #1;
        d  = model_decode(ins);
        st = model_stall(d);
        obs_stall = stall_f;
        check_eq("stall_f", 32'(stall_f), 32'(st));
        @(posedge clk);
        #1;
        if (we && wr != 0) m_rf[wr] = wd;
        exp_e = (fl || st) ? zero_e() : d;
        if (fl) pc = 16'($urandom_range(0, 16'hFFFE)) & 16'hFFFE;
        else if (!st) pc = pc + 16'd2;
        compare_outputs("step");
    endtask

    initial begin
        logic [15:0] ins;
        bit          hold;
        foreach (m_rf[i]) m_rf[i] = 16'h0;
        exp_e = zero_e();
        rst = 1'b0; instr_d = 16'h1245; pc_d = pc; pc_next_d = pc + 16'd2;
        flush_d = 0; reg_write_w = 0; rd_w = 0; result_w = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        compare_outputs("reset");
        check_eq("reset stall_f", 32'(stall_f), 32'd0);
        rst = 1'b1;

        // First edge after release captures the presented ADDI r1,r1,5
        step(16'h1245, 0, 0, 0, 0);
        check_eq("addi reg_write_e", 32'(reg_write_e), 32'd1);
        check_eq("addi rd_e", 32'(rd_e), 32'd1);
        check_eq("addi rs1_e", 32'(rs1_e), 32'd1);
        check_eq("addi imm_e", 32'(imm_e), 32'h0005);
        check_eq("addi alu_src_e", 32'(alu_src_e), 32'd1);

        // Writeback r3 then R-type reading r3 twice, rd=r0
        step(16'h1000, 0, 1, 3'd3, 16'hBEEF);
        step(16'h00D8, 0, 0, 0, 0);
        check_eq("rtype rd1_e", 32'(rd1_e), 32'hBEEF);
        check_eq("rtype rd2_e", 32'(rd2_e), 32'hBEEF);
        check_eq("rtype reg_write_e", 32'(reg_write_e), 32'd0);

        // Immediate extremes
        step(16'h103F, 0, 0, 0, 0); check_eq("addi imm min", 32'(imm_e), 32'hFFFF);
        step(16'h403E, 0, 0, 0, 0); check_eq("beq imm", 32'(imm_e), 32'hFFFC);
        step(16'h51FF, 0, 0, 0, 0); check_eq("jal imm", 32'(imm_e), 32'hFFFE);
        step(16'h6001, 0, 0, 0, 0); check_eq("lui imm", 32'(imm_e), 32'h0080);

        // Load-use: LW r2 then ADD r4,r2,r1
        step(16'h2400, 0, 0, 0, 0);
        step(16'h0888, 0, 0, 0, 0);
        check_eq("loaduse stall", 32'(obs_stall), 32'd1);
        check_eq("loaduse bubble rw", 32'(reg_write_e), 32'd0);
        check_eq("loaduse bubble rd", 32'(rd_e), 32'd0);
        step(16'h0888, 0, 0, 0, 0);
        check_eq("loaduse release stall", 32'(obs_stall), 32'd0);
        check_eq("loaduse rs1_e", 32'(rs1_e), 32'd2);
        check_eq("loaduse rd_e", 32'(rd_e), 32'd4);

        // Flush beats load-use; illegal opcode becomes a marked NOP
        step(16'h2400, 0, 0, 0, 0);
        step(16'h0888, 1, 0, 0, 0);
        check_eq("flush stall", 32'(obs_stall), 32'd0);
        check_eq("flush bubble rw", 32'(reg_write_e), 32'd0);
        check_eq("flush bubble rs1", 32'(rs1_e), 32'd0);
        step(16'hF000, 0, 0, 0, 0);
        check_eq("illegal_e", 32'(illegal_e), 32'd1);
        check_eq("illegal reg_write_e", 32'(reg_write_e), 32'd0);

        // Same-cycle writeback of r5 while ADDI r1,r5,0 reads it
        step(16'h1000, 0, 1, 3'd5, 16'h1111);
        step(16'h1340, 0, 1, 3'd5, 16'h1234);
`ifdef DECODE_WB_BYPASS_EN
        check_eq("bypass stall", 32'(obs_stall), 32'd0);
        check_eq("bypass rd1_e", 32'(rd1_e), 32'h1234);
`else
        check_eq("wb stall", 32'(obs_stall), 32'd1);
        check_eq("wb bubble rw", 32'(reg_write_e), 32'd0);
        step(16'h1340, 0, 0, 0, 0);
        check_eq("wb stall released", 32'(obs_stall), 32'd0);
        check_eq("wb rd1_e", 32'(rd1_e), 32'h1234);
`endif

        // Random streams; a stalled instruction is re-presented like fetch would
        ins = 16'h0; hold = 0;
        for (int n = 0; n < 600; n++) begin
            if (!hold) begin
                ins = 16'($urandom_range(0, 16'hFFFF));
                ins[15:12] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(7, 15))
                                                         : 4'($urandom_range(0, 6));
            end
            step(ins, $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
                 3'($urandom_range(0, 7)), 16'($urandom_range(0, 16'hFFFF)));
            hold = obs_stall;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
